// File: rtl/branch_sched_if.sv
// Bundle of the decode, NZP-register and fetch/PC signals around the branch
// sequencing controller.
//   master : decode/NZP side; drives the decode fields and nzp_val, observes
//            the controller outputs.
//   slave  : the controller itself.
// Signals: dec_valid, dec_is_cmp, dec_is_br, dec_br_mask[2:0] {n,z,p},
//          dec_target[7:0], nzp_val[2:0] {lt,eq,gt}, nzp_en, stall, pc_load,
//          next_pc[7:0], flush, br_total[7:0], br_taken[7:0].
interface branch_sched_if;
    logic       dec_valid;
    logic       dec_is_cmp;
    logic       dec_is_br;
    logic [2:0] dec_br_mask;
    logic [7:0] dec_target;
    logic [2:0] nzp_val;
    logic       nzp_en;
    logic       stall;
    logic       pc_load;
    logic [7:0] next_pc;
    logic       flush;
    logic [7:0] br_total;
    logic [7:0] br_taken;

    modport master (
        output dec_valid, dec_is_cmp, dec_is_br, dec_br_mask, dec_target, nzp_val,
        input  nzp_en, stall, pc_load, next_pc, flush, br_total, br_taken
    );

    modport slave (
        input  dec_valid, dec_is_cmp, dec_is_br, dec_br_mask, dec_target, nzp_val,
        output nzp_en, stall, pc_load, next_pc, flush, br_total, br_taken
    );
endinterface

// File: rtl/branch_sched.sv
// Branch sequencing controller for the pipelined GPU core.
// Times the NZP-register write enable for each CMP, stalls conditional
// branches until every older CMP has written the flags, resolves BRnzp
// against the flags (PC redirect + flush of fetch/decode on taken) and keeps
// wrap-around branch statistics.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : branch_sched_if.slave (decode inputs, nzp_val in; nzp_en, stall,
//           pc_load, next_pc, flush, br_total, br_taken out)
// Parameters:
//   CMP_LAT      : cycles from CMP acceptance to flags valid (1..4)
//   FLUSH_CYCLES : cycles flush is held after a taken branch (1..7)
module branch_sched #(
    parameter int CMP_LAT      = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_sched_if.slave        bus
);
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t     state, state_next;
    logic [2:0] flush_cnt, flush_cnt_next;
    logic [7:0] br_total, br_taken;
    logic       cmp_acc;
    logic       br_req;
    logic       pend;
    logic       nzp_en;
    logic       taken;
    logic       resolve;
    logic       pc_load;

    // CMP wins over BR when both flags are set, so a BR request never
    // coincides with a CMP acceptance and stall never gates a CMP.
    assign cmp_acc = (state == RUN) & bus.dec_valid & bus.dec_is_cmp;
    assign br_req  = (state == RUN) & bus.dec_valid & bus.dec_is_br & ~bus.dec_is_cmp;

    generate
        if (CMP_LAT == 1) begin : g_lat1
            assign nzp_en = cmp_acc;
            assign pend   = nzp_en;
        end else begin : g_latn
            // Stage CMP_LAT-2 is the last register; its output is the
            // write enable, so the enable lands CMP_LAT-1 cycles after accept.
            logic [CMP_LAT-2:0] cmp_vld_p;

            always_ff @(posedge clk) begin
                if (reset) begin
                    cmp_vld_p <= '0;
                end else begin
                    cmp_vld_p[0] <= cmp_acc;
                    for (int i = 1; i < CMP_LAT - 1; i++) begin
                        cmp_vld_p[i] <= cmp_vld_p[i-1];
                    end
                end
            end

            assign nzp_en = cmp_vld_p[CMP_LAT-2];
            assign pend   = |cmp_vld_p;
        end
    endgenerate

    assign taken   = |(bus.dec_br_mask & bus.nzp_val);
    assign resolve = br_req & ~pend;
    assign pc_load = resolve & taken;

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            RUN: begin
                if (pc_load) begin
                    state_next     = FLUSH;
                    flush_cnt_next = 3'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                flush_cnt_next = flush_cnt - 3'd1;
                if (flush_cnt <= 3'd1) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            flush_cnt <= '0;
            br_total  <= '0;
            br_taken  <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            if (resolve) begin
                br_total <= br_total + 8'd1;
            end
            if (pc_load) begin
                br_taken <= br_taken + 8'd1;
            end
        end
    end

    assign bus.nzp_en   = nzp_en;
    assign bus.stall    = br_req & pend;
    assign bus.pc_load  = pc_load;
    assign bus.next_pc  = pc_load ? bus.dec_target : 8'd0;
    assign bus.flush    = (state == FLUSH);
    assign bus.br_total = br_total;
    assign bus.br_taken = br_taken;
endmodule

// File: tb/tb_branch_sched.sv
// Testbench for branch_sched with default parameters (CMP_LAT=2,
// FLUSH_CYCLES=2). Each record is one clock cycle of stimulus plus the
// outputs expected during that cycle.
module tb_branch_sched;
    logic clk;
    logic reset;

    branch_sched_if bus();

    branch_sched #(.CMP_LAT(2), .FLUSH_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        logic       cmp;
        logic       br;
        logic [2:0] mask;
        logic [7:0] tgt;
        logic [2:0] nzp;
        logic       chk;
        logic       en;
        logic       st;
        logic       pcl;
        logic [7:0] npc;
        logic       fl;
        logic [7:0] tot;
        logic [7:0] tk;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t sb[$];

    function automatic vec_t mk(input logic rst, valid, cmp, br,
                                input logic [2:0] mask, input logic [7:0] tgt,
                                input logic [2:0] nzp,
                                input logic en, st, pcl, input logic [7:0] npc,
                                input logic fl, input logic [7:0] tot, tk);
        vec_t v;
        v.rst = rst; v.valid = valid; v.cmp = cmp; v.br = br;
        v.mask = mask; v.tgt = tgt; v.nzp = nzp; v.chk = 1'b1;
        v.en = en; v.st = st; v.pcl = pcl; v.npc = npc; v.fl = fl;
        v.tot = tot; v.tk = tk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle shortly after the rising edge, check at the falling edge.
    task automatic cycle(input string tag, input int idx, input vec_t v);
        vec_t e;
        reset           = v.rst;
        bus.dec_valid   = v.valid;
        bus.dec_is_cmp  = v.cmp;
        bus.dec_is_br   = v.br;
        bus.dec_br_mask = v.mask;
        bus.dec_target  = v.tgt;
        bus.nzp_val     = v.nzp;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        if (e.chk) begin
            chk($sformatf("%s[%0d].nzp_en",   tag, idx), 8'(bus.nzp_en),  8'(e.en));
            chk($sformatf("%s[%0d].stall",    tag, idx), 8'(bus.stall),   8'(e.st));
            chk($sformatf("%s[%0d].pc_load",  tag, idx), 8'(bus.pc_load), 8'(e.pcl));
            chk($sformatf("%s[%0d].next_pc",  tag, idx), bus.next_pc,     e.npc);
            chk($sformatf("%s[%0d].flush",    tag, idx), 8'(bus.flush),   8'(e.fl));
            chk($sformatf("%s[%0d].br_total", tag, idx), bus.br_total,    e.tot);
            chk($sformatf("%s[%0d].br_taken", tag, idx), bus.br_taken,    e.tk);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    vec_t v;

    initial begin
        reset           = 1'b1;
        bus.dec_valid   = 1'b0;
        bus.dec_is_cmp  = 1'b0;
        bus.dec_is_br   = 1'b0;
        bus.dec_br_mask = 3'b000;
        bus.dec_target  = 8'h00;
        bus.nzp_val     = 3'b000;

        //            rst v  c  b  mask    tgt    nzp     en st pl npc    fl tot tk
        // reset for two cycles, then a branch before any CMP
        v = mk(1, 0, 0, 0, 3'b000, 8'h00, 3'b000, 0, 0, 0, 8'h00, 0, 0, 0);
        v.chk = 1'b0;
        tbl_a.push_back(v);
        tbl_a.push_back(mk(1, 0, 0, 0, 3'b000, 8'h00, 3'b000, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl_a.push_back(mk(0, 1, 0, 1, 3'b111, 8'h40, 3'b000, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl_a.push_back(mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b000, 0, 0, 0, 8'h00, 0, 1, 0));
        // CMP at T, BR at T+1 stalls, resolves taken at T+2, flush T+3..T+4
        tbl_a.push_back(mk(0, 1, 1, 0, 3'b000, 8'h00, 3'b000, 0, 0, 0, 8'h00, 0, 1, 0));
        tbl_a.push_back(mk(0, 1, 0, 1, 3'b010, 8'h33, 3'b000, 1, 1, 0, 8'h00, 0, 1, 0));
        tbl_a.push_back(mk(0, 1, 0, 1, 3'b010, 8'h33, 3'b010, 0, 0, 1, 8'h33, 0, 1, 0));
        // decode activity during FLUSH is ignored
        tbl_a.push_back(mk(0, 1, 0, 1, 3'b010, 8'h55, 3'b010, 0, 0, 0, 8'h00, 1, 2, 1));
        tbl_a.push_back(mk(0, 1, 1, 0, 3'b000, 8'h00, 3'b010, 0, 0, 0, 8'h00, 1, 2, 1));
        tbl_a.push_back(mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b010, 0, 0, 0, 8'h00, 0, 2, 1));
        // not-taken branch
        tbl_a.push_back(mk(0, 1, 0, 1, 3'b011, 8'h77, 3'b100, 0, 0, 0, 8'h00, 0, 2, 1));
        tbl_a.push_back(mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b100, 0, 0, 0, 8'h00, 0, 3, 1));
        // three back-to-back CMPs, then a BR
        tbl_a.push_back(mk(0, 1, 1, 0, 3'b000, 8'h00, 3'b100, 0, 0, 0, 8'h00, 0, 3, 1));
        tbl_a.push_back(mk(0, 1, 1, 0, 3'b000, 8'h00, 3'b100, 1, 0, 0, 8'h00, 0, 3, 1));
        tbl_a.push_back(mk(0, 1, 1, 0, 3'b000, 8'h00, 3'b100, 1, 0, 0, 8'h00, 0, 3, 1));
        tbl_a.push_back(mk(0, 1, 0, 1, 3'b100, 8'h21, 3'b100, 1, 1, 0, 8'h00, 0, 3, 1));
        tbl_a.push_back(mk(0, 1, 0, 1, 3'b100, 8'h21, 3'b100, 0, 0, 1, 8'h21, 0, 3, 1));
        tbl_a.push_back(mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b100, 0, 0, 0, 8'h00, 1, 4, 2));
        tbl_a.push_back(mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b100, 0, 0, 0, 8'h00, 1, 4, 2));
        tbl_a.push_back(mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b100, 0, 0, 0, 8'h00, 0, 4, 2));
        // CMP and BR flags together: CMP only
        tbl_a.push_back(mk(0, 1, 1, 1, 3'b111, 8'h99, 3'b100, 0, 0, 0, 8'h00, 0, 4, 2));
        tbl_a.push_back(mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b100, 1, 0, 0, 8'h00, 0, 4, 2));
        tbl_a.push_back(mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b100, 0, 0, 0, 8'h00, 0, 4, 2));
        // reset ahead of the wrap run
        tbl_a.push_back(mk(1, 0, 0, 0, 3'b000, 8'h00, 3'b000, 0, 0, 0, 8'h00, 0, 4, 2));

        // after the wrap run: reset inside FLUSH, then reset dropping a CMP
        tbl_b.push_back(mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b111, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl_b.push_back(mk(0, 1, 0, 1, 3'b111, 8'h5a, 3'b111, 0, 0, 1, 8'h5a, 0, 0, 0));
        tbl_b.push_back(mk(1, 0, 0, 0, 3'b000, 8'h00, 3'b111, 0, 0, 0, 8'h00, 1, 1, 1));
        tbl_b.push_back(mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b001, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl_b.push_back(mk(0, 1, 0, 1, 3'b001, 8'h12, 3'b001, 0, 0, 1, 8'h12, 0, 0, 0));
        tbl_b.push_back(mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b001, 0, 0, 0, 8'h00, 1, 1, 1));
        tbl_b.push_back(mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b001, 0, 0, 0, 8'h00, 1, 1, 1));
        tbl_b.push_back(mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b001, 0, 0, 0, 8'h00, 0, 1, 1));
        tbl_b.push_back(mk(1, 1, 1, 0, 3'b000, 8'h00, 3'b001, 0, 0, 0, 8'h00, 0, 1, 1));
        tbl_b.push_back(mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b001, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl_b.push_back(mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b001, 0, 0, 0, 8'h00, 0, 0, 0));

        @(posedge clk);
        #1;

        foreach (tbl_a[i]) cycle("seq", i, tbl_a[i]);

        // 256 taken branches: counters climb 0..255 and wrap to 0
        for (int i = 0; i < 256; i++) begin
            cycle("wrap_br", i, mk(0, 1, 0, 1, 3'b111, 8'(i), 3'b111,
                                   0, 0, 1, 8'(i), 0, 8'(i), 8'(i)));
            cycle("wrap_fl1", i, mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b111,
                                    0, 0, 0, 8'h00, 1, 8'(i + 1), 8'(i + 1)));
            cycle("wrap_fl2", i, mk(0, 0, 0, 0, 3'b000, 8'h00, 3'b111,
                                    0, 0, 0, 8'h00, 1, 8'(i + 1), 8'(i + 1)));
        end

        foreach (tbl_b[i]) cycle("rst", i, tbl_b[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
